param_normal_queue: RTL and testbench

- Single-clock, parametrised successor to the bisynchronous normal queue.
- Supports any depth ≥1 (not only powers of 2) and three operating modes: normal, pipe and bypass.
- Adds an occupancy count, an almost-full flag and a synchronous flush.
- Used as the general-purpose buffering element between single-clock-domain CGRA tiles and routers.

---
 rtl/param_normal_queue.sv | 145 ++++++++++++++
 tb/tb_param_normal_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_normal_queue.sv
// rtl/param_normal_queue.sv - single-clock parametrised FIFO with normal, pipe and bypass modes
module param_normal_queue #(
    parameter int p_data_width         = 32,
    parameter int p_num_entries        = 4,
    parameter int p_mode               = 0,
    parameter int p_almost_full_thresh = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 w_val,
    output logic                                 w_rdy,
    input  logic [p_data_width-1:0]              w_msg,
    output logic                                 r_val,
    input  logic                                 r_rdy,
    output logic [p_data_width-1:0]              r_msg,
    output logic [$clog2(p_num_entries+1)-1:0]   count,
    output logic                                 almost_full
);

    localparam int CW = $clog2(p_num_entries + 1);
    localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(p_num_entries - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(p_num_entries);
    localparam logic [CW-1:0] AF_CNT   = CW'(p_almost_full_thresh);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam bit MODE_PIPE   = (p_mode == 1);
    localparam bit MODE_BYPASS = (p_mode == 2);

    logic [p_data_width-1:0] mem_q [p_num_entries];

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic active;
    logic fwd;
    logic bypass_go;
    logic w_go;
    logic r_go;
    logic store;
    logic deq;

    // Handshake generation: readiness depends on mode; reset and flush mask both sides.
    always_comb begin
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        active = reset & ~flush;

        w_rdy = 1'b0;
        r_val = 1'b0;
        if (active) begin
            if (MODE_PIPE) begin
                w_rdy = ~full | r_rdy;
                r_val = ~empty;
            end else if (MODE_BYPASS) begin
                w_rdy = ~full;
                r_val = ~empty | w_val;
            end else begin
                w_rdy = ~full;
                r_val = ~empty;
            end
        end

        // An empty bypass queue presents the incoming word directly on the read side.
        fwd       = MODE_BYPASS & empty & w_val;
        w_go      = w_val & w_rdy;
        r_go      = r_val & r_rdy;
        bypass_go = fwd & w_go & r_go;

        // A word consumed straight through the bypass never touches storage.
        store = w_go & ~bypass_go;
        deq   = r_go & ~bypass_go;
    end

    // Read data: forwarded word, head of storage, or zero when nothing is offered.
    always_comb begin
        r_msg = '0;
        if (r_val) begin
            if (fwd) begin
                r_msg = w_msg;
            end else begin
                r_msg = mem_q[r_ptr_q];
            end
        end
    end

    // Next-state for pointers and occupancy; wrap uses an explicit compare so any depth works.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;

        if (store) begin
            w_ptr_d = (w_ptr_q == LAST_PTR) ? '0 : (w_ptr_q + PTR_ONE);
        end
        if (deq) begin
            r_ptr_d = (r_ptr_q == LAST_PTR) ? '0 : (r_ptr_q + PTR_ONE);
        end

        if (store && !deq) begin
            count_d = count_q + CNT_ONE;
        end else if (deq && !store) begin
            count_d = count_q - CNT_ONE;
        end

        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[w_ptr_q] <= w_msg;
        end
    end

    // Status outputs come straight from the count register, held low during reset.
    always_comb begin
        count       = reset ? count_q : '0;
        almost_full = reset & (count_q >= AF_CNT);
    end

endmodule

// File: tb/tb_param_normal_queue.sv
// tb/tb_param_normal_queue.sv - self-checking bench for param_normal_queue
module tb_param_normal_queue;

    localparam int SOAK_CYCLES = 10000;
    localparam int N_SOAK      = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic soak_go;
    int   soak_done;
    int   n_tests;
    int   n_fail;

    // directed instances: 0 = normal depth 3, 1 = pipe depth 2, 2 = bypass depth 4
    logic        d_fl   [3];
    logic        d_wv   [3];
    logic [7:0]  d_wm   [3];
    logic        d_rr   [3];
    logic        d_wrdy [3];
    logic        d_rval [3];
    logic [7:0]  d_rm   [3];
    logic        d_af   [3];
    logic [31:0] d_cnt  [3];
    logic [1:0]  a_cnt;
    logic [1:0]  b_cnt;
    logic [2:0]  c_cnt;

    assign d_cnt[0] = 32'(a_cnt);
    assign d_cnt[1] = 32'(b_cnt);
    assign d_cnt[2] = 32'(c_cnt);

    param_normal_queue #(.p_data_width(8), .p_num_entries(3), .p_mode(0), .p_almost_full_thresh(3)) u_a (
        .clk(clk), .reset(rst_n), .flush(d_fl[0]),
        .w_val(d_wv[0]), .w_rdy(d_wrdy[0]), .w_msg(d_wm[0]),
        .r_val(d_rval[0]), .r_rdy(d_rr[0]), .r_msg(d_rm[0]),
        .count(a_cnt), .almost_full(d_af[0])
    );

    param_normal_queue #(.p_data_width(8), .p_num_entries(2), .p_mode(1), .p_almost_full_thresh(2)) u_b (
        .clk(clk), .reset(rst_n), .flush(d_fl[1]),
        .w_val(d_wv[1]), .w_rdy(d_wrdy[1]), .w_msg(d_wm[1]),
        .r_val(d_rval[1]), .r_rdy(d_rr[1]), .r_msg(d_rm[1]),
        .count(b_cnt), .almost_full(d_af[1])
    );

    param_normal_queue #(.p_data_width(8), .p_num_entries(4), .p_mode(2), .p_almost_full_thresh(3)) u_c (
        .clk(clk), .reset(rst_n), .flush(d_fl[2]),
        .w_val(d_wv[2]), .w_rdy(d_wrdy[2]), .w_msg(d_wm[2]),
        .r_val(d_rval[2]), .r_rdy(d_rr[2]), .r_msg(d_rm[2]),
        .count(c_cnt), .almost_full(d_af[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         dut;
        logic       fl;
        logic       wv;
        logic [7:0] wm;
        logic       rr;
        logic       e_wrdy;
        logic       e_rval;
        logic [7:0] e_rm;
        int         e_cnt;
        logic       e_af;
    } vec_t;

    function automatic vec_t mk(int dut, logic fl, logic wv, logic [7:0] wm, logic rr,
                                logic e_wrdy, logic e_rval, logic [7:0] e_rm, int e_cnt, logic e_af);
        vec_t v;
        v.dut = dut; v.fl = fl; v.wv = wv; v.wm = wm; v.rr = rr;
        v.e_wrdy = e_wrdy; v.e_rval = e_rval; v.e_rm = e_rm; v.e_cnt = e_cnt; v.e_af = e_af;
        return v;
    endfunction

    // random soak: every mode against depths 1, 3 and 4 with a queue model
    for (genvar g = 0; g < N_SOAK; g++) begin : g_soak
        localparam int MODE = g / 3;
        localparam int DEP  = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 3 : 4);
        localparam int CWS  = $clog2(DEP + 1);

        logic           wv, rr, wrdy, rval, af;
        logic [7:0]     wm, rm;
        logic [CWS-1:0] cnt;

        param_normal_queue #(.p_data_width(8), .p_num_entries(DEP), .p_mode(MODE), .p_almost_full_thresh(DEP)) u_s (
            .clk(clk), .reset(rst_n), .flush(1'b0),
            .w_val(wv), .w_rdy(wrdy), .w_msg(wm),
            .r_val(rval), .r_rdy(rr), .r_msg(rm),
            .count(cnt), .almost_full(af)
        );

        initial begin
            logic [7:0] q[$];
            logic [7:0] nxt;
            logic [7:0] exp_rm;
            logic       e_wrdy, e_rval, wgo, rgo;
            string      tag;
            wv = 1'b0; rr = 1'b0; wm = '0;
            nxt = 8'(g * 16);
            tag = $sformatf("soak m%0d d%0d", MODE, DEP);
            wait (soak_go);
            for (int c = 0; c < SOAK_CYCLES; c++) begin
                @(negedge clk);
                wv = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                wm = nxt;
                #1;
                e_wrdy = (q.size() < DEP) || (MODE == 1 && rr);
                e_rval = (q.size() > 0) || (MODE == 2 && wv);
                exp_rm = !e_rval ? 8'h00 : ((q.size() > 0) ? q[0] : wm);
                check({tag, " w_rdy"}, 32'(wrdy), 32'(e_wrdy));
                check({tag, " r_val"}, 32'(rval), 32'(e_rval));
                check({tag, " r_msg"}, 32'(rm), 32'(exp_rm));
                check({tag, " count"}, 32'(cnt), 32'(q.size()));
                check({tag, " almost_full"}, 32'(af), 32'(q.size() >= DEP));
                wgo = wv & e_wrdy;
                rgo = rr & e_rval;
                if (!(MODE == 2 && q.size() == 0 && wv && rr)) begin
                    if (rgo) void'(q.pop_front());
                    if (wgo) q.push_back(wm);
                end
                if (wgo) nxt = nxt + 8'd1;
            end
            @(negedge clk);
            wv = 1'b0; rr = 1'b0;
            soak_done++;
        end
    end

    initial begin
        vec_t vecs[$];
        int   waited;
        n_tests = 0; n_fail = 0; soak_done = 0; soak_go = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_fl[k] = 1'b0; d_wv[k] = 1'b0; d_wm[k] = '0; d_rr[k] = 1'b0;
        end

        // normal depth 3: fill past full, drain, refill across the wrap, flush
        vecs.push_back(mk(0,0,1,8'hAA,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0, 1,1,8'hAA,1,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'hAA,1,0));
        vecs.push_back(mk(0,0,1,8'h01,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,8'h02,0, 1,1,8'h01,1,0));
        vecs.push_back(mk(0,0,1,8'h03,0, 1,1,8'h01,2,0));
        vecs.push_back(mk(0,0,1,8'h04,0, 0,1,8'h01,3,1));
        vecs.push_back(mk(0,0,1,8'h04,1, 0,1,8'h01,3,1));
        vecs.push_back(mk(0,0,1,8'h04,1, 1,1,8'h02,2,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'h03,2,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'h04,1,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,8'h05,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,8'h06,0, 1,1,8'h05,1,0));
        vecs.push_back(mk(0,0,1,8'h07,0, 1,1,8'h05,2,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 0,1,8'h05,3,1));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'h06,2,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'h07,1,0));
        vecs.push_back(mk(0,0,1,8'h08,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,8'h09,0, 1,1,8'h08,1,0));
        vecs.push_back(mk(0,1,1,8'h0A,1, 0,0,8'h00,2,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,8'h0B,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,8'h0B,1,0));
        vecs.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,0,0));
        // pipe depth 2: enqueue into a full queue while dequeuing
        vecs.push_back(mk(1,0,1,8'h10,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(1,0,1,8'h11,0, 1,1,8'h10,1,0));
        vecs.push_back(mk(1,0,1,8'h12,0, 0,1,8'h10,2,1));
        vecs.push_back(mk(1,0,1,8'h12,1, 1,1,8'h10,2,1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h11,2,1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h12,1,0));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0,0));
        // bypass depth 4: pass-through, then stored when the reader stalls
        vecs.push_back(mk(2,0,1,8'h55,1, 1,1,8'h55,0,0));
        vecs.push_back(mk(2,0,0,8'h00,1, 1,0,8'h00,0,0));
        vecs.push_back(mk(2,0,1,8'h55,0, 1,1,8'h55,0,0));
        vecs.push_back(mk(2,0,0,8'h00,0, 1,1,8'h55,1,0));
        vecs.push_back(mk(2,0,1,8'h66,1, 1,1,8'h55,1,0));
        vecs.push_back(mk(2,0,1,8'h77,1, 1,1,8'h66,1,0));
        vecs.push_back(mk(2,0,0,8'h00,1, 1,1,8'h77,1,0));
        vecs.push_back(mk(2,0,0,8'h00,0, 1,0,8'h00,0,0));

        // reset held for two cycles with a write pending
        d_wv[0] = 1'b1; d_wm[0] = 8'hAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("reset%0d dut%0d w_rdy", c, k), 32'(d_wrdy[k]), 32'd0);
                check($sformatf("reset%0d dut%0d r_val", c, k), 32'(d_rval[k]), 32'd0);
                check($sformatf("reset%0d dut%0d r_msg", c, k), 32'(d_rm[k]), 32'd0);
                check($sformatf("reset%0d dut%0d count", c, k), d_cnt[k], 32'd0);
                check($sformatf("reset%0d dut%0d almost_full", c, k), 32'(d_af[k]), 32'd0);
            end
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                d_fl[k] = 1'b0; d_wv[k] = 1'b0; d_wm[k] = '0; d_rr[k] = 1'b0;
            end
            d_fl[vecs[i].dut] = vecs[i].fl;
            d_wv[vecs[i].dut] = vecs[i].wv;
            d_wm[vecs[i].dut] = vecs[i].wm;
            d_rr[vecs[i].dut] = vecs[i].rr;
            #1;
            check($sformatf("v%0d w_rdy", i), 32'(d_wrdy[vecs[i].dut]), 32'(vecs[i].e_wrdy));
            check($sformatf("v%0d r_val", i), 32'(d_rval[vecs[i].dut]), 32'(vecs[i].e_rval));
            check($sformatf("v%0d r_msg", i), 32'(d_rm[vecs[i].dut]), 32'(vecs[i].e_rm));
            check($sformatf("v%0d count", i), d_cnt[vecs[i].dut], 32'(vecs[i].e_cnt));
            check($sformatf("v%0d almost_full", i), 32'(d_af[vecs[i].dut]), 32'(vecs[i].e_af));
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            d_fl[k] = 1'b0; d_wv[k] = 1'b0; d_wm[k] = '0; d_rr[k] = 1'b0;
        end

        soak_go = 1'b1;
        waited = 0;
        while (soak_done < N_SOAK && waited < SOAK_CYCLES + 2000) begin
            @(negedge clk);
            waited++;
        end
        check("soak completion", 32'(soak_done), 32'(N_SOAK));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
